// File: rtl/action_scheduler.sv
// ============================================================================
//  Module      : action_scheduler
//  Description : Arbitrates button and CV action requesters into a small FIFO
//                and releases at most one action per video frame as player
//                move/jump pulses and a slide_hold level.
//                Optional macro ACTION_SCHED_COALESCE_EN cancels opposing
//                LEFT/RIGHT pairs against the FIFO tail.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module action_scheduler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     frame_done,
    input  logic                     game_active,
    input  logic                     btn_valid,
    input  logic [2:0]               btn_action,
    output logic                     btn_ready,
    input  logic                     cv_valid,
    input  logic [2:0]               cv_action,
    output logic                     cv_ready,
    input  logic                     is_jumping,
    input  logic                     is_sliding,
    output logic                     move_left_pulse,
    output logic                     move_right_pulse,
    output logic                     jump_pulse,
    output logic                     slide_hold,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    localparam logic [2:0] c_ACT_LEFT      = 3'd1;
    localparam logic [2:0] c_ACT_RIGHT     = 3'd2;
    localparam logic [2:0] c_ACT_JUMP      = 3'd3;
    localparam logic [2:0] c_ACT_SLIDE_ON  = 3'd4;
    localparam logic [2:0] c_ACT_SLIDE_OFF = 3'd5;

    logic [2:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_prio_cv;
    logic                r_left;
    logic                r_right;
    logic                r_jump;
    logic                r_slide;
    logic [CNT_W-1:0]    r_drop;

    logic                w_btn_real;
    logic                w_cv_real;
    logic                w_pop;
    logic                w_room;
    logic                w_grant_btn;
    logic                w_grant_cv;
    logic                w_push_any;
    logic [2:0]          w_push_act;
    logic                w_cancel;
    logic                w_write;
    logic [2:0]          w_head;
    logic                w_jump_blocked;

    // Codes 0, 6 and 7 are swallowed without touching the queue
    function automatic logic f_is_real(input logic [2:0] a);
        return (a >= c_ACT_LEFT) && (a <= c_ACT_SLIDE_OFF);
    endfunction

    assign w_btn_real = btn_valid && f_is_real(btn_action);
    assign w_cv_real  = cv_valid  && f_is_real(cv_action);
    assign w_pop      = game_active && frame_done && (r_count != '0);
    assign w_room     = (r_count != c_FULL) || w_pop;

    // r_prio_cv=1 means btn was granted last, so cv wins a tie
    assign w_grant_btn = w_room && w_btn_real && (!w_cv_real || !r_prio_cv);
    assign w_grant_cv  = w_room && w_cv_real  && (!w_btn_real || r_prio_cv);
    assign w_push_any  = game_active && (w_grant_btn || w_grant_cv);
    assign w_push_act  = w_grant_btn ? btn_action : cv_action;

    assign btn_ready = !game_active ||
                       (btn_valid && (!f_is_real(btn_action) || w_grant_btn));
    assign cv_ready  = !game_active ||
                       (cv_valid && (!f_is_real(cv_action) || w_grant_cv));

    assign w_head         = r_mem[r_rd_ptr];
    assign w_jump_blocked = is_jumping || is_sliding;

`ifdef ACTION_SCHED_COALESCE_EN
    logic [c_PTR_W-1:0]  w_tail_ptr;
    logic [2:0]          w_tail;
    logic [c_CNT_W-1:0]  w_min_count;

    assign w_tail_ptr  = r_wr_ptr - c_PTR_W'(1);
    assign w_tail      = r_mem[w_tail_ptr];
    // A tail that is also being popped this cycle cannot be cancelled
    assign w_min_count = w_pop ? c_CNT_W'(1) : c_CNT_W'(0);
    assign w_cancel    = w_push_any && (r_count > w_min_count) &&
                         (((w_push_act == c_ACT_LEFT)  && (w_tail == c_ACT_RIGHT)) ||
                          ((w_push_act == c_ACT_RIGHT) && (w_tail == c_ACT_LEFT)));
`else
    assign w_cancel = 1'b0;
`endif

    assign w_write = w_push_any && !w_cancel;

    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_push_act;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_prio_cv <= 1'b0;
            r_left    <= 1'b0;
            r_right   <= 1'b0;
            r_jump    <= 1'b0;
            r_slide   <= 1'b0;
            r_drop    <= '0;
        end else if (!game_active) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_left    <= 1'b0;
            r_right   <= 1'b0;
            r_jump    <= 1'b0;
            r_slide   <= 1'b0;
        end else begin
            r_left  <= w_pop && (w_head == c_ACT_LEFT);
            r_right <= w_pop && (w_head == c_ACT_RIGHT);
            r_jump  <= w_pop && (w_head == c_ACT_JUMP) && !w_jump_blocked;

            if (w_pop && (w_head == c_ACT_JUMP) && w_jump_blocked && (r_drop != '1)) begin
                r_drop <= r_drop + CNT_W'(1);
            end

            if (w_pop && (w_head == c_ACT_SLIDE_ON)) begin
                r_slide <= 1'b1;
            end else if (w_pop && (w_head == c_ACT_SLIDE_OFF)) begin
                r_slide <= 1'b0;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            if (w_cancel) begin
                r_wr_ptr <= r_wr_ptr - c_PTR_W'(1);
            end else if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end

            r_count <= r_count + c_CNT_W'(w_write) - c_CNT_W'(w_pop) - c_CNT_W'(w_cancel);

            if (w_grant_btn) begin
                r_prio_cv <= 1'b1;
            end else if (w_grant_cv) begin
                r_prio_cv <= 1'b0;
            end
        end
    end

    assign move_left_pulse  = r_left;
    assign move_right_pulse = r_right;
    assign jump_pulse       = r_jump;
    assign slide_hold       = r_slide;
    assign queue_count      = r_count;
    assign drop_count       = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_action_scheduler.sv
// ============================================================================
//  Module      : tb_action_scheduler
//  Description : Scoreboard bench for action_scheduler against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_action_scheduler;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int DROPMAX = (1 << CNT_W) - 1;
    localparam int LEFT = 1, RIGHT = 2, JUMP = 3, SON = 4, SOFF = 5;

    logic clock = 1'b0;
    logic reset, frame_done, game_active, btn_valid, cv_valid, is_jumping, is_sliding;
    logic [2:0] btn_action, cv_action;
    logic btn_ready, cv_ready, move_left_pulse, move_right_pulse, jump_pulse, slide_hold;
    logic [$clog2(DEPTH):0] queue_count;
    logic [CNT_W-1:0] drop_count;

    always #5 clock = ~clock;

    action_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .frame_done(frame_done), .game_active(game_active),
        .btn_valid(btn_valid), .btn_action(btn_action), .btn_ready(btn_ready),
        .cv_valid(cv_valid), .cv_action(cv_action), .cv_ready(cv_ready),
        .is_jumping(is_jumping), .is_sliding(is_sliding),
        .move_left_pulse(move_left_pulse), .move_right_pulse(move_right_pulse),
        .jump_pulse(jump_pulse), .slide_hold(slide_hold),
        .queue_count(queue_count), .drop_count(drop_count)
    );

    typedef struct { int cyc; logic [2:0] p; } exp_t;
    exp_t sbq[$];
    int   mq[$];
    bit   m_prio_cv;
    int   m_drop;
    bit   m_slide;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   b_acc, c_acc;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit real_code(input int a);
        return (a >= LEFT) && (a <= SOFF);
    endfunction

    // One clock of stimulus; the model predicts readies, then the new state
    task automatic step(input bit ga, input bit fd, input bit bv, input int ba,
                        input bit cvv, input int ca, input bit isj, input bit iss);
        bit pop, room, eb, ec;
        int winner, h, a;
        @(negedge clock);
        game_active = ga; frame_done = fd; btn_valid = bv; btn_action = 3'(ba);
        cv_valid = cvv; cv_action = 3'(ca); is_jumping = isj; is_sliding = iss;
        #1;
        winner = 0;
        pop = 0;
        if (!ga) begin
            eb = 1; ec = 1;
        end else begin
            pop  = fd && (mq.size() > 0);
            room = (mq.size() < DEPTH) || pop;
            if (room) begin
                if (bv && real_code(ba) && cvv && real_code(ca)) winner = m_prio_cv ? 2 : 1;
                else if (bv && real_code(ba)) winner = 1;
                else if (cvv && real_code(ca)) winner = 2;
            end
            eb = bv  && (!real_code(ba) || winner == 1);
            ec = cvv && (!real_code(ca) || winner == 2);
        end
        chk("btn_ready", btn_ready, eb);
        chk("cv_ready", cv_ready, ec);
        b_acc = eb && bv;
        c_acc = ec && cvv;
        if (!ga) begin
            mq.delete();
            m_slide = 0;
        end else begin
            if (pop) begin
                h = mq.pop_front();
                case (h)
                    LEFT:  sbq.push_back('{cyc + 1, 3'b100});
                    RIGHT: sbq.push_back('{cyc + 1, 3'b010});
                    JUMP:  if (isj || iss) m_drop = (m_drop < DROPMAX) ? m_drop + 1 : m_drop;
                           else sbq.push_back('{cyc + 1, 3'b001});
                    SON:   m_slide = 1;
                    SOFF:  m_slide = 0;
                    default: ;
                endcase
            end
            if (winner != 0) begin
                a = (winner == 1) ? ba : ca;
                m_prio_cv = (winner == 1);
`ifdef ACTION_SCHED_COALESCE_EN
                if (mq.size() > 0 && ((a == LEFT && mq[$] == RIGHT) || (a == RIGHT && mq[$] == LEFT)))
                    mq.pop_back();
                else
                    mq.push_back(a);
`else
                mq.push_back(a);
`endif
            end
        end
        @(posedge clock);
        #1;
        chk("queue_count", queue_count, mq.size());
        chk("drop_count", drop_count, m_drop);
        chk("slide_hold", slide_hold, m_slide);
    endtask

    task automatic idle(input int n, input bit fd);
        for (int i = 0; i < n; i++) step(1, fd, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1; game_active = 0; frame_done = 0; btn_valid = 0; cv_valid = 0;
        #1;
        chk("rst_count", queue_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_slide", slide_hold, 0);
        chk("rst_pulses", {move_left_pulse, move_right_pulse, jump_pulse}, 0);
        mq.delete();
        m_drop = 0; m_slide = 0; m_prio_cv = 0;
        @(negedge clock);
        reset = 0;
    endtask

    // Monitor: compares pulse outputs against the scoreboard every cycle
    initial begin
        logic [2:0] p;
        forever begin
            @(posedge clock);
            #2;
            p = {move_left_pulse, move_right_pulse, jump_pulse};
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                chk("pulse_late", cyc, sbq[0].cyc);
                sbq.delete(0);
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                chk("pulse", p, sbq[0].p);
                sbq.delete(0);
            end else if (p != 3'b000) begin
                chk("pulse_unexpected", p, 0);
            end
        end
    end

    initial begin
        bit bv, cvv;
        int ba, ca;
        reset = 1; game_active = 0; frame_done = 0; btn_valid = 0; cv_valid = 0;
        btn_action = 0; cv_action = 0; is_jumping = 0; is_sliding = 0;
        m_prio_cv = 0; m_drop = 0; m_slide = 0;
        repeat (2) @(negedge clock);
        do_reset();

        // Three actions queued in frame 0, released one per frame
        step(1, 0, 1, LEFT, 0, 0, 0, 0);
        step(1, 0, 1, RIGHT, 0, 0, 0, 0);
        step(1, 0, 1, JUMP, 0, 0, 0, 0);
`ifndef ACTION_SCHED_COALESCE_EN
        chk("t1_count", queue_count, 3);
`endif
        for (int f = 0; f < 3; f++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            idle(2, 0);
        end
        chk("t1_empty", queue_count, 0);

        // Both requesters contend until full, then a pop frees a slot for cv
        for (int i = 0; i < 5; i++) step(1, 0, 1, LEFT, 1, RIGHT, 0, 0);
`ifndef ACTION_SCHED_COALESCE_EN
        chk("t2_full", queue_count, 4);
`endif
        step(1, 1, 0, 0, 1, JUMP, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 0, 0, 0);

        // Blocked jumps drive the drop counter into saturation
        for (int i = 0; i < 260; i++) step(1, 1, 1, JUMP, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        chk("t4_drop_sat", drop_count, DROPMAX);

        // Slide hold, then a flush that must swallow a queued RIGHT
        step(1, 0, 0, 0, 1, SON, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, RIGHT, 0, 0, 0, 0);
        step(0, 0, 1, LEFT, 1, 0, 0, 0);
        chk("t5_flush", queue_count, 0);
        idle(3, 1);

        // Opposing moves back to back
        step(1, 0, 1, RIGHT, 0, 0, 0, 0);
        step(1, 0, 1, LEFT, 0, 0, 0, 0);
        idle(1, 0);
        for (int f = 0; f < 3; f++) step(1, 1, 0, 0, 0, 0, 0, 0);

        // Reset with a pulse in flight
        step(1, 0, 1, LEFT, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Randomized traffic with held-until-accepted sources
        bv = 0; cvv = 0; ba = 0; ca = 0; b_acc = 0; c_acc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!bv || b_acc) begin bv = ($urandom_range(0, 2) != 0); ba = $urandom_range(0, 7); end
            if (!cvv || c_acc) begin cvv = ($urandom_range(0, 2) != 0); ca = $urandom_range(0, 7); end
            step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, bv, ba, cvv, ca,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        idle(3, 0);
        chk("sb_drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
